// File: rtl/seq_pkg.sv
// Shared types and constants for the LEGv8 cycle sequencer.
// State encoding, strobe bit positions and the default watchdog limit.
package seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DREAD  = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALTED = 3'd5
   } seq_state_t;

   localparam int STB_FETCH = 0;
   localparam int STB_DREAD = 1;
   localparam int STB_MEM   = 2;
   localparam int STB_WB    = 3;
   localparam int STB_N     = 4;

   localparam int DEF_MEM_TIMEOUT = 15;

   // One-hot strobe vector for a state; at most one bit is ever set.
   function automatic logic [STB_N-1:0] strobe_decode(seq_state_t s);
      logic [STB_N-1:0] v;
      v = '0;
      v[STB_FETCH] = (s == FETCH);
      v[STB_DREAD] = (s == DREAD);
      v[STB_MEM]   = (s == MEM);
      v[STB_WB]    = (s == WB);
      return v;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM cycles spent waiting on data memory.
// expire flags the wait cycle that would bring the count to TIMEOUT.
module mem_wait_timer
   import seq_pkg::*;
#(
   parameter int TIMEOUT = DEF_MEM_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expire
);

   localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear dominates, otherwise advance on a wait cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count_en) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = count_en & ~clear & (cnt_q == LAST);

endmodule

// File: rtl/cycle_sequencer.sv
// Single-clock instruction sequencer for the non-pipelined LEGv8 datapath.
// Steps FETCH/DREAD/MEM/WB with run/step/halt control and a memory watchdog.
module cycle_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned MAX_INSTR   = 0,
   parameter int          CNT_W       = 32,
   parameter int          MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic             halt_req,
   input  logic             mem_access,
   input  logic             mem_ready,
   output logic             instr_mem_en,
   output logic             read_en,
   output logic             memory_en,
   output logic             write_en,
   output logic             pc_en,
   output logic             busy,
   output logic             halted,
   output logic             timeout_err,
   output logic [CNT_W-1:0] instr_count,
   output logic [2:0]       state
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INSTR);

   seq_state_t       state_q, state_d;
   logic             step_q, step_d;
   logic             terr_q, terr_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             limit_hit;
   logic             wait_clr;
   logic             wait_en;
   logic             wait_expire;
   logic [STB_N-1:0] stb;

   assign wait_clr = (state_q != MEM);
   assign wait_en  = (state_q == MEM) & mem_access & ~mem_ready;

   mem_wait_timer #(
      .TIMEOUT (MEM_TIMEOUT)
   ) u_wait (
      .clk      (clk),
      .reset    (reset),
      .clear    (wait_clr),
      .count_en (wait_en),
      .expire   (wait_expire)
   );

   assign cnt_inc   = instr_count_q + CNT_W'(1);
   assign limit_hit = (MAX_INSTR != 0) && (cnt_inc == MAX_C);
   assign step_d    = step;

   // Next state, retire counting and sticky watchdog error.
   always_comb begin
      state_d       = state_q;
      instr_count_d = instr_count_q;
      terr_d        = terr_q;
      case (state_q)
         IDLE: begin
            if (run || (step && !step_q)) begin
               state_d = FETCH;
            end
         end
         FETCH:  state_d = DREAD;
         DREAD:  state_d = MEM;
         MEM: begin
            if (!mem_access || mem_ready) begin
               state_d = WB;
            end else if (wait_expire) begin
               state_d = HALTED;
               terr_d  = 1'b1;
            end
         end
         WB: begin
            if (instr_count_q != '1) begin
               instr_count_d = cnt_inc;
            end
            if (halt_req || limit_hit) begin
               state_d = HALTED;
            end else if (run) begin
               state_d = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = IDLE;
      endcase
   end

   // State and control registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         step_q        <= 1'b0;
         terr_q        <= 1'b0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         terr_q        <= terr_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign stb          = strobe_decode(state_q);
   assign instr_mem_en = stb[STB_FETCH];
   assign read_en      = stb[STB_DREAD];
   assign memory_en    = stb[STB_MEM];
   assign write_en     = stb[STB_WB];
   assign pc_en        = stb[STB_WB];
   assign busy         = |stb;
   assign halted       = (state_q == HALTED);
   assign timeout_err  = terr_q;
   assign instr_count  = instr_count_q;
   assign state        = state_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer.
// Three parameterisations share one stimulus stream.
module tb_cycle_sequencer;
   import seq_pkg::*;

   logic clk = 1'b0;
   logic reset, run, step, halt_req, mem_access, mem_ready;

   logic        instr_mem_en, read_en, memory_en, write_en, pc_en;
   logic        busy, halted, timeout_err;
   logic [31:0] instr_count;
   logic [2:0]  state;

   logic        b_imem, b_rd, b_mem, b_wr, b_pc, b_busy, b_halt, b_terr;
   logic [2:0]  b_cnt;
   logic [2:0]  b_state;

   logic        c_imem, c_rd, c_mem, c_wr, c_pc, c_busy, c_halt, c_terr;
   logic [1:0]  c_cnt;
   logic [2:0]  c_state;

   always #5 clk = ~clk;

   cycle_sequencer dut (
      .clk(clk), .reset(reset), .run(run), .step(step),
      .halt_req(halt_req), .mem_access(mem_access),
      .mem_ready(mem_ready), .instr_mem_en(instr_mem_en),
      .read_en(read_en), .memory_en(memory_en),
      .write_en(write_en), .pc_en(pc_en), .busy(busy),
      .halted(halted), .timeout_err(timeout_err),
      .instr_count(instr_count), .state(state)
   );

   cycle_sequencer #(.MAX_INSTR(4), .CNT_W(3), .MEM_TIMEOUT(2)) dut_b (
      .clk(clk), .reset(reset), .run(run), .step(step),
      .halt_req(halt_req), .mem_access(mem_access),
      .mem_ready(mem_ready), .instr_mem_en(b_imem),
      .read_en(b_rd), .memory_en(b_mem), .write_en(b_wr),
      .pc_en(b_pc), .busy(b_busy), .halted(b_halt),
      .timeout_err(b_terr), .instr_count(b_cnt), .state(b_state)
   );

   cycle_sequencer #(.MAX_INSTR(0), .CNT_W(2), .MEM_TIMEOUT(1)) dut_c (
      .clk(clk), .reset(reset), .run(run), .step(step),
      .halt_req(halt_req), .mem_access(mem_access),
      .mem_ready(mem_ready), .instr_mem_en(c_imem),
      .read_en(c_rd), .memory_en(c_mem), .write_en(c_wr),
      .pc_en(c_pc), .busy(c_busy), .halted(c_halt),
      .timeout_err(c_terr), .instr_count(c_cnt), .state(c_state)
   );

   logic [6:0] outs;
   assign outs = {instr_mem_en, read_en, memory_en, write_en,
                  pc_en, busy, halted};

   typedef struct packed {
      logic       rst;
      logic       run;
      logic       step;
      logic       hreq;
      logic       macc;
      logic       mrdy;
      logic [2:0] st;
      logic [7:0] cnt;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h",
                  nm, $time, act, exp);
      end
   endtask

   function automatic vec_t v(input logic r, input logic ru,
                              input logic s, input logic h,
                              input logic ma, input logic mr,
                              input logic [2:0] st,
                              input logic [7:0] c);
      vec_t t;
      t.rst = r; t.run = ru; t.step = s; t.hreq = h;
      t.macc = ma; t.mrdy = mr; t.st = st; t.cnt = c;
      return t;
   endfunction

   // Strobe/busy/halted pattern the spec assigns to each state.
   function automatic logic [6:0] exp_out(input logic [2:0] st);
      return {st == 3'd1, st == 3'd2, st == 3'd3, st == 3'd4,
              st == 3'd4, (st >= 3'd1 && st <= 3'd4), st == 3'd5};
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      run = 0; step = 0; halt_req = 0;
      mem_access = 0; mem_ready = 0;
      #1;
      chk("rst_outs", {25'd0, outs}, 32'd0);
      chk("rst_cnt", instr_count, 32'd0);
      chk("rst_terr", {31'd0, timeout_err}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   vec_t tbl[$];
   int   pc_b, late_b, hb, ma_a, wr_a, ha, ma_b, ma_c, hc;

   initial begin
      reset = 1; run = 0; step = 0; halt_req = 0;
      mem_access = 0; mem_ready = 0;

      // A: free run, no memory access; pc_en at cycles 5, 9, 13
      for (int k = 0; k < 14; k++) begin
         tbl.push_back(v(k == 0, 1, 0, 0, 0, 0,
                         (k == 0) ? 3'd0 : 3'((k - 1) % 4 + 1),
                         (k == 0) ? 8'd0 : 8'((k - 1) / 4)));
      end
      // B: step held for 9 cycles -> exactly one instruction
      tbl.push_back(v(1, 0, 0, 0, 0, 0, IDLE,  0));
      tbl.push_back(v(0, 0, 1, 0, 0, 0, IDLE,  0));
      tbl.push_back(v(0, 0, 1, 0, 0, 0, FETCH, 0));
      tbl.push_back(v(0, 0, 1, 0, 0, 0, DREAD, 0));
      tbl.push_back(v(0, 0, 1, 0, 0, 0, MEM,   0));
      tbl.push_back(v(0, 0, 1, 0, 0, 0, WB,    0));
      for (int k = 7; k <= 16; k++) begin
         tbl.push_back(v(0, 0, k <= 10, 0, 0, 0, IDLE, 1));
      end
      // C: run drops mid-instruction, memory ready on 3rd MEM cycle
      tbl.push_back(v(1, 1, 0, 0, 0, 0, IDLE,  0));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, FETCH, 0));
      tbl.push_back(v(0, 0, 0, 0, 1, 1, DREAD, 0));
      tbl.push_back(v(0, 0, 0, 0, 1, 0, MEM,   0));
      tbl.push_back(v(0, 0, 0, 0, 1, 0, MEM,   0));
      tbl.push_back(v(0, 0, 0, 0, 1, 1, MEM,   0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, WB,    0));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, IDLE,  1));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, IDLE,  1));
      // D: halt_req only acts in WB; HALTED ignores run/step
      tbl.push_back(v(1, 1, 0, 1, 0, 0, IDLE,   0));
      tbl.push_back(v(0, 1, 0, 1, 0, 0, FETCH,  0));
      tbl.push_back(v(0, 1, 0, 1, 0, 0, DREAD,  0));
      tbl.push_back(v(0, 1, 0, 1, 0, 0, MEM,    0));
      tbl.push_back(v(0, 1, 0, 0, 0, 0, WB,     0));
      tbl.push_back(v(0, 1, 0, 1, 0, 0, FETCH,  1));
      tbl.push_back(v(0, 1, 0, 1, 0, 0, DREAD,  1));
      tbl.push_back(v(0, 1, 0, 1, 0, 0, MEM,    1));
      tbl.push_back(v(0, 1, 0, 1, 0, 0, WB,     1));
      tbl.push_back(v(0, 1, 1, 0, 0, 0, HALTED, 2));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, HALTED, 2));
      tbl.push_back(v(0, 1, 1, 0, 0, 0, HALTED, 2));
      // E: run and step together behave as free-run
      tbl.push_back(v(1, 1, 1, 0, 0, 0, IDLE,  0));
      tbl.push_back(v(0, 1, 1, 0, 0, 0, FETCH, 0));
      tbl.push_back(v(0, 1, 1, 0, 0, 0, DREAD, 0));
      tbl.push_back(v(0, 1, 1, 0, 0, 0, MEM,   0));
      tbl.push_back(v(0, 1, 1, 0, 0, 0, WB,    0));
      tbl.push_back(v(0, 1, 1, 0, 0, 0, FETCH, 1));

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         run = tbl[i].run; step = tbl[i].step;
         halt_req = tbl[i].hreq;
         mem_access = tbl[i].macc; mem_ready = tbl[i].mrdy;
         @(negedge clk);
         chk($sformatf("vec%0d_state", i), {29'd0, state},
             {29'd0, tbl[i].st});
         chk($sformatf("vec%0d_outs", i), {25'd0, outs},
             {25'd0, exp_out(tbl[i].st)});
         chk($sformatf("vec%0d_cnt", i), instr_count,
             {24'd0, tbl[i].cnt});
         tick();
      end

      // MAX_INSTR=4: four retirements, halt at cycle 18, then inert
      do_reset();
      run = 1;
      pc_b = 0; late_b = 0; hb = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c >= 25) begin
            run = (c % 2 == 1);
            step = (c % 3 == 0);
         end
         @(negedge clk);
         pc_b += int'(b_pc);
         if (c >= 19)
            late_b += int'(b_imem | b_rd | b_mem | b_wr | b_pc);
         if (b_halt && hb == 0) hb = c;
         tick();
      end
      chk("max_pc_pulses", pc_b, 4);
      chk("max_late_strobes", late_b, 0);
      chk("max_halt_cycle", hb, 18);
      chk("max_cnt", {29'd0, b_cnt}, 32'd4);
      chk("max_halted", {31'd0, b_halt}, 32'd1);
      chk("max_terr", {31'd0, b_terr}, 32'd0);

      // Watchdog: one good instruction, then memory never ready
      do_reset();
      run = 1; mem_access = 1; mem_ready = 1;
      ma_a = 0; wr_a = 0; ha = 0; ma_b = 0; ma_c = 0; hc = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c >= 5) mem_ready = 0;
         @(negedge clk);
         ma_a += int'(memory_en);
         wr_a += int'(write_en);
         ma_b += int'(b_mem);
         ma_c += int'(c_mem);
         if (halted && ha == 0) ha = c;
         if (c_halt && hc == 0) hc = c;
         tick();
      end
      chk("to_mem_cycles", ma_a, 16);
      chk("to_wr_cycles", wr_a, 1);
      chk("to_halt_cycle", ha, 23);
      chk("to_terr", {31'd0, timeout_err}, 32'd1);
      chk("to_halted", {31'd0, halted}, 32'd1);
      chk("to_cnt", instr_count, 32'd1);
      chk("to2_mem_cycles", ma_b, 3);
      chk("to2_terr", {31'd0, b_terr}, 32'd1);
      chk("to1_mem_cycles", ma_c, 2);
      chk("to1_halt_cycle", hc, 9);
      chk("to1_cnt", {30'd0, c_cnt}, 32'd1);

      // mem_ready on the would-be timeout cycle wins; counter clears
      do_reset();
      mem_access = 1;
      for (int c = 1; c <= 24; c++) begin
         run = (c == 1 || c >= 19);
         mem_ready = (c == 18 || c == 23);
         @(negedge clk);
         if (c == 18) chk("edge_mem", {29'd0, state}, 32'd3);
         if (c == 19) chk("edge_wb", {29'd0, state}, 32'd4);
         if (c == 19) chk("edge_terr", {31'd0, timeout_err}, 32'd0);
         if (c == 23) chk("clr_mem", {29'd0, state}, 32'd3);
         if (c == 24) chk("clr_wb", {29'd0, state}, 32'd4);
         if (c == 24) chk("clr_terr", {31'd0, timeout_err}, 32'd0);
         tick();
      end

      // Counter saturation on the 2-bit instance
      do_reset();
      run = 1;
      repeat (30) tick();
      @(negedge clk);
      chk("sat_cnt", {30'd0, c_cnt}, 32'd3);
      chk("sat_halted", {31'd0, c_halt}, 32'd0);
      chk("sat_wide_cnt", instr_count, 32'd7);
      tick();

      // Reset during MEM of the second instruction
      do_reset();
      run = 1;
      repeat (7) tick();
      chk("mid_pre_mem", {31'd0, memory_en}, 32'd1);
      chk("mid_pre_cnt", instr_count, 32'd1);
      reset = 1;
      #1;
      chk("mid_rst_outs", {25'd0, outs}, 32'd0);
      chk("mid_rst_cnt", instr_count, 32'd0);
      chk("mid_rst_state", {29'd0, state}, 32'd0);
      tick();
      reset = 0;
      @(negedge clk);
      chk("mid_rel_idle", {29'd0, state}, 32'd0);
      tick();
      @(negedge clk);
      chk("mid_rel_fetch", {25'd0, outs}, {25'd0, exp_out(3'd1)});

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
